// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC generation, synchronous ROM fetch and IF/ID register with stall/redirect.
// Define IF_HALT_EN to detect the all-ones HALT word and freeze the stage once it retires.
module instr_fetch_stage #(
  parameter int INSTR_W = 21,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_id,
  output logic [ADDR_W-1:0]  pc_id,
  output logic               valid_id,
  output logic               halted
);
  logic [ADDR_W-1:0] pc_f, pc_q;
  logic req_valid, halt_hit;
  assign imem_addr = pc_f;
  // the ROM keeps its output register while disabled, so a stalled fetch survives
  assign imem_en = rst | branch_taken | (~stall & ~halted);
`ifdef IF_HALT_EN
  logic halt_q;
  assign halt_hit = valid_id & (&instr_id) & ~stall & ~branch_taken;
  assign halted = halt_q;
  always_ff @(posedge clk) halt_q <= ~rst & (halt_q | halt_hit);
`else
  assign halt_hit = 1'b0;
  assign halted = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      pc_f <= RESET_PC;
      pc_q <= '0;
      req_valid <= 1'b0;
      instr_id <= '0;
      pc_id <= '0;
      valid_id <= 1'b0;
    end else if (branch_taken) begin
      pc_f <= branch_target;
      req_valid <= 1'b0;
      instr_id <= '0;
      valid_id <= 1'b0;
    end else if (halted | halt_hit) begin
      valid_id <= 1'b0;
    end else if (~stall) begin
      pc_q <= pc_f;
      pc_f <= pc_f + 1'b1;
      req_valid <= 1'b1;
      instr_id <= imem_rdata;
      pc_id <= pc_q;
      valid_id <= req_valid;
    end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: randomized and directed checks of instr_fetch_stage against a fetch-queue model.
module tb_instr_fetch_stage;
`ifdef IF_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam logic [20:0] HALT = 21'h1FFFFF;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, branch_taken = 1'b0;
  logic [7:0] branch_target = '0, imem_addr, pc_id;
  logic imem_en, valid_id, halted;
  logic [20:0] imem_rdata = '0, instr_id;
  logic [20:0] mem [256];
  int errors = 0, checks = 0;

  instr_fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_rdata(imem_rdata), .instr_id(instr_id), .pc_id(pc_id),
    .valid_id(valid_id), .halted(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Reference: a FIFO of issued fetch addresses; an instruction leaves one issuing edge after entering.
  logic [7:0] fq[$];
  logic [7:0] m_nxt, m_pc;
  logic [20:0] m_ins;
  bit m_ok = 0, m_v, m_halt, m_pck, m_ik;
  always @(posedge clk) begin
    if (rst) begin
      fq.delete(); m_nxt = 8'h00; m_v = 0; m_pc = 0; m_ins = 0;
      m_pck = 1; m_ik = 1; m_halt = 0; m_ok = 1;
    end else if (branch_taken) begin
      fq.delete(); m_nxt = branch_target; m_v = 0; m_ins = 0; m_ik = 1;
    end else if (m_halt || (HALT_EN && m_v && m_ins == HALT && !stall)) begin
      m_halt = 1; m_v = 0;
    end else if (!stall) begin
      fq.push_back(m_nxt);
      m_nxt = m_nxt + 8'd1;
      if (fq.size() > 1) begin
        m_pc = fq.pop_front(); m_v = 1; m_ins = mem[m_pc]; m_pck = 1; m_ik = 1;
      end else begin
        m_v = 0; m_pck = 0; m_ik = 0;
      end
    end
  end

  always @(negedge clk) if (m_ok) begin
    chk("valid_id", valid_id, m_v);
    if (m_pck) chk("pc_id", pc_id, m_pc);
    if (m_ik) chk("instr_id", instr_id, m_ins);
    chk("halted", halted, m_halt);
    chk("imem_addr", imem_addr, m_nxt);
    chk("imem_en", imem_en, rst | branch_taken | (!stall && !m_halt));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic out(input string n, input logic v, input logic [7:0] pc, input logic [20:0] ins);
    chk({n, "_v"}, valid_id, v);
    chk({n, "_pc"}, pc_id, pc);
    chk({n, "_ins"}, instr_id, ins);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 21'(i + 'h100);
    tick; tick;
    rst = 0;
    tick;
    chk("first_bubble", valid_id, 1'b0);
    tick;
    out("rel0", 1'b1, 8'h00, 21'h100);
    for (int k = 1; k <= 5; k++) begin
      tick;
      out("seq", 1'b1, 8'(k), 21'(k + 'h100));
    end
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      out("stall_hold", 1'b1, 8'h05, 21'h105);
    end
    stall = 0;
    tick;
    out("stall_next", 1'b1, 8'h06, 21'h106);
    repeat (4) tick;
    out("pre_br", 1'b1, 8'h0A, 21'h10A);
    branch_taken = 1; branch_target = 8'h40;
    tick;
    branch_taken = 0;
    out("br_b1", 1'b0, 8'h0A, 21'h0);
    tick;
    chk("br_b2", valid_id, 1'b0);
    tick;
    out("br_tgt", 1'b1, 8'h40, 21'h140);
    branch_taken = 1; stall = 1; branch_target = 8'h80;
    tick;
    branch_taken = 0; stall = 0;
    chk("brst_b1", valid_id, 1'b0);
    tick; tick;
    out("brst_tgt", 1'b1, 8'h80, 21'h180);
    branch_taken = 1; branch_target = 8'hFE;
    tick;
    branch_taken = 0;
    tick; tick;
    out("wrap_fe", 1'b1, 8'hFE, 21'h1FE);
    tick;
    out("wrap_ff", 1'b1, 8'hFF, 21'h1FF);
    tick;
    out("wrap_00", 1'b1, 8'h00, 21'h100);
    tick;
    out("wrap_01", 1'b1, 8'h01, 21'h101);
    stall = 1;
    tick;
    rst = 1;
    tick;
    out("rst_mid", 1'b0, 8'h00, 21'h0);
    chk("rst_mid_halt", halted, 1'b0);
    mem[8'h77] = HALT;
    rst = 0; stall = 0;
    tick; tick;
    out("rst_rel", 1'b1, 8'h00, 21'h100);
    for (int c = 0; c < 2000; c++) begin
      tick;
      rst = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 99) < 30);
      branch_taken = ($urandom_range(0, 99) < 6);
      branch_target = 8'($urandom);
    end
    rst = 1; stall = 0; branch_taken = 0;
    tick;
    mem[3] = HALT;
    rst = 0;
    repeat (5) tick;
    out("halt_id", 1'b1, 8'h03, HALT);
    tick;
    chk("halt_set", halted, HALT_EN);
    chk("halt_last", valid_id, !HALT_EN);
    tick;
    chk("halt_en", imem_en, !HALT_EN);
    chk("halt_frozen", valid_id, !HALT_EN);
    rst = 1;
    tick;
    rst = 0;
    repeat (5) tick;
    out("halt_wp", 1'b1, 8'h03, HALT);
    branch_taken = 1; branch_target = 8'h20;
    tick;
    branch_taken = 0;
    chk("halt_killed", halted, 1'b0);
    chk("halt_kill_v", valid_id, 1'b0);
    tick; tick;
    out("halt_redir", 1'b1, 8'h20, 21'h120);
    chk("halt_redir_h", halted, 1'b0);
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction fetch stage and IF/ID pipeline register of the vector processor. Generates the program counter, drives the synchronous instruction ROM, and presents a 21-bit instruction word plus its PC and a valid flag to the decode stage (control unit). Supports pipeline stall from the hazard logic and PC redirect from the execute stage. Optionally detects a HALT instruction.

## Interface
- INSTR_W, 21, instruction word width (bit 20 funct, 19:17 opcode, 16 imm flag)
- ADDR_W, 8, instruction ROM address / PC width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC, in-flight fetch and IF/ID register
- branch_taken  in  1  redirect request from execute stage
- branch_target  in  ADDR_W  redirect address, sampled when branch_taken=1
- imem_addr  out  ADDR_W  ROM read address (= pc_f register)
- imem_en  out  1  ROM read enable; ROM holds its output register when 0
- imem_rdata  in  INSTR_W  ROM data, valid one cycle after imem_addr/imem_en
- instr_id  out  INSTR_W  instruction to decode
- pc_id  out  ADDR_W  address of instr_id
- valid_id  out  1  instr_id is a real instruction (0 = bubble)
- halted  out  1  HALT retired from ID (tied 0 without IF_HALT_EN)

## Operation
- Internal state: pc_f (address being presented), pc_q (address of in-flight fetch), req_valid (in-flight fetch is real), IF/ID register (instr_id, pc_id, valid_id), halted.
- imem_addr = pc_f; imem_en = rst | branch_taken | (~stall & ~halted).
- Priority per edge: rst > branch_taken > halted > stall > normal.
- rst: pc_f=RESET_PC, pc_q=0, req_valid=0, instr_id=0, pc_id=0, valid_id=0, halted=0.
- branch_taken: pc_f<=branch_target, req_valid<=0, instr_id<=0, valid_id<=0; pc_id unchanged. Overrides a simultaneous stall.
- halted: all state frozen, valid_id<=0.
- stall: pc_f, pc_q, req_valid and IF/ID register all hold; ROM output held via imem_en=0, so no fetch is lost.
- normal: pc_q<=pc_f; pc_f<=pc_f+1 modulo 2^ADDR_W (wrap 0xFF->0x00, no flag); req_valid<=1; instr_id<=imem_rdata; pc_id<=pc_q; valid_id<=req_valid.
- Non-valid slots carry instr_id=0 only after reset/redirect; decode must qualify on valid_id.

## Timing
- Reset release to first valid_id=1: 2 rising edges (edge 1 issues fetch of RESET_PC, edge 2 captures it).
- Branch penalty: 2 bubble cycles; instr_id=mem[target] with valid_id=1 on the 2nd edge after the edge sampling branch_taken.
- Stall of N cycles delays all outputs by exactly N cycles; sequence unchanged, no duplicates.
- rst mid-operation wins over everything in the same cycle; in-flight fetch discarded.
- Steady state: one instruction per cycle, consecutive pc_id values.

## Configuration
- IF_HALT_EN defined: HALT = all-ones instruction (21'h1FFFFF). halted<=1 on the edge where valid_id=1, instr_id=HALT, stall=0, branch_taken=0 (a concurrent redirect marks the HALT wrong-path and kills it). halted is sticky until rst; the HALT itself is the last valid_id=1 output.
- IF_HALT_EN undefined: no detection, halted tied 0, all-ones word treated as an ordinary instruction.

## Test plan
- Reset release with ROM mem[i]=i+0x100 -> valid_id=1 on 2nd edge, pc_id=0, instr_id=0x100; then pc_id 1,2,3 with instr_id 0x101,0x102,0x103.
- stall high 3 cycles while pc_id=5 -> instr_id/pc_id/valid_id held 3 cycles, then pc_id=6 follows with no skipped or repeated address.
- branch_taken with target 0x40 while pc_id=10 -> 2 cycles valid_id=0, then pc_id=0x40, instr_id=mem[0x40]; branch_taken and stall together -> redirect still taken.
- PC at 0xFE, no stalls -> pc_id sequence 0xFE, 0xFF, 0x00, 0x01.
- rst asserted one cycle during stall mid-stream -> next edge all outputs 0, halted=0; first valid_id 2 edges after release with pc_id=RESET_PC.
- IF_HALT_EN: mem[3]=21'h1FFFFF -> pc_id=3 valid once, halted=1 next edge, valid_id=0 and imem_en=0 thereafter; same HALT with branch_taken in its ID cycle -> halted stays 0.
